// File: rtl/frame_bank_scheduler_if.sv
// Bank-request handshake between the camera writer, the LCD reader and frame_bank_scheduler.
interface frame_bank_scheduler_if #(
  parameter int ADDR_W = 21
);
  logic              wr_frame_start;
  logic              wr_frame_done;
  logic              wr_frame_abort;
  logic              wr_grant;
  logic [ADDR_W-1:0] wr_base;
  logic              wr_drop;
  logic              rd_frame_start;
  logic              rd_frame_done;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_base;
  logic              rd_fresh;
  logic [15:0]       frames_dropped;

  modport master (
    output wr_frame_start, wr_frame_done, wr_frame_abort,
    output rd_frame_start, rd_frame_done,
    input  wr_grant, wr_base, wr_drop,
    input  rd_valid, rd_base, rd_fresh, frames_dropped
  );

  modport slave (
    input  wr_frame_start, wr_frame_done, wr_frame_abort,
    input  rd_frame_start, rd_frame_done,
    output wr_grant, wr_base, wr_drop,
    output rd_valid, rd_base, rd_fresh, frames_dropped
  );
endinterface

// File: rtl/frame_bank_scheduler.sv
// PSRAM frame-bank ownership tracker between camera writer and LCD reader.
// Define FRAME_BANK_TRIPLE_EN for three banks; otherwise two banks (double buffering).
module frame_bank_scheduler #(
  parameter int                ADDR_W      = 21,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 21'h000000,
  parameter logic [ADDR_W-1:0] BANK_STRIDE = 21'h040000
) (
  input  logic PixelClk,
  input  logic nRST,
  input  logic init_done,
  frame_bank_scheduler_if.slave bus
);

`ifdef FRAME_BANK_TRIPLE_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int IDX_W = $clog2(NB);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    READING = 2'd3
  } bank_state_t;

  typedef bank_state_t [NB-1:0] bank_vec_t;

  bank_vec_t          bank_r,       bank_s;
  logic [NB-1:0]      seen_r,       seen_s;
  logic [IDX_W-1:0]   latest_r,     latest_s;
  logic               latest_vld_r, latest_vld_s;
  logic [IDX_W-1:0]   wr_idx_r,     wr_idx_s;
  logic [IDX_W-1:0]   rd_idx_r,     rd_idx_s;
  logic               wr_grant_r,   wr_grant_s;
  logic               rd_valid_r,   rd_valid_s;
  logic               rd_fresh_r,   rd_fresh_s;
  logic               wr_drop_r,    wr_drop_s;
  logic [ADDR_W-1:0]  wr_base_r;
  logic [ADDR_W-1:0]  rd_base_r;
  logic [15:0]        frames_dropped_r;
  logic               drop_evt_s;
  logic               wr_alloc_s;
  logic               rd_alloc_s;
  logic [IDX_W:0]     pick_free_s;
  logic [IDX_W:0]     pick_ready_s;

  function automatic logic [IDX_W:0] find_lowest(input bank_vec_t s, input bank_state_t want);
    logic [IDX_W:0] res;
    res = {(IDX_W+1){1'b0}};
    for (int i = NB - 1; i >= 0; i--) begin
      if (s[i] == want) begin
        res = {1'b1, IDX_W'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [ADDR_W-1:0] bank_base(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * BANK_STRIDE;
  endfunction

  // Next bank ownership: reader release, writer completion, writer allocation, reader acquisition.
  always_comb begin
    bank_s       = bank_r;
    seen_s       = seen_r;
    latest_s     = latest_r;
    latest_vld_s = latest_vld_r;
    wr_idx_s     = wr_idx_r;
    rd_idx_s     = rd_idx_r;
    wr_grant_s   = wr_grant_r;
    rd_valid_s   = rd_valid_r;
    rd_fresh_s   = rd_fresh_r;
    wr_drop_s    = 1'b0;
    drop_evt_s   = 1'b0;
    wr_alloc_s   = 1'b0;
    rd_alloc_s   = 1'b0;
    pick_free_s  = {(IDX_W+1){1'b0}};
    pick_ready_s = {(IDX_W+1){1'b0}};

    if (bus.rd_frame_done && rd_valid_s) begin
      bank_s[rd_idx_s] = (latest_vld_s && (latest_s == rd_idx_s)) ? READY : FREE;
      rd_valid_s       = 1'b0;
    end else begin
      rd_valid_s = rd_valid_s;
    end

    // A superseded latest frame still on screen is freed later by the reader's done.
    if (bus.wr_frame_done && wr_grant_s) begin
      if (latest_vld_s && (bank_s[latest_s] == READY)) begin
        bank_s[latest_s] = FREE;
      end else begin
        bank_s = bank_s;
      end
      bank_s[wr_idx_s] = READY;
      seen_s[wr_idx_s] = 1'b0;
      latest_s         = wr_idx_s;
      latest_vld_s     = 1'b1;
      wr_grant_s       = 1'b0;
    end else if (bus.wr_frame_abort && wr_grant_s) begin
      bank_s[wr_idx_s] = FREE;
      wr_grant_s       = 1'b0;
    end else begin
      wr_grant_s = wr_grant_s;
    end

    if (bus.wr_frame_start) begin
      if (wr_grant_s) begin
        bank_s[wr_idx_s] = FREE;
        wr_grant_s       = 1'b0;
        drop_evt_s       = 1'b1;
      end else begin
        wr_grant_s = wr_grant_s;
      end
      pick_free_s  = find_lowest(bank_s, FREE);
      pick_ready_s = find_lowest(bank_s, READY);
      if (pick_free_s[IDX_W]) begin
        wr_idx_s   = pick_free_s[IDX_W-1:0];
        wr_alloc_s = 1'b1;
      end else if (pick_ready_s[IDX_W]) begin
        wr_idx_s     = pick_ready_s[IDX_W-1:0];
        wr_alloc_s   = 1'b1;
        drop_evt_s   = 1'b1;
        latest_vld_s = latest_vld_s && (latest_s != pick_ready_s[IDX_W-1:0]);
      end else begin
        wr_drop_s  = 1'b1;
        drop_evt_s = 1'b1;
      end
      if (wr_alloc_s) begin
        bank_s[wr_idx_s] = WRITING;
        wr_grant_s       = 1'b1;
      end else begin
        wr_grant_s = wr_grant_s;
      end
    end else begin
      wr_drop_s = 1'b0;
    end

    if (bus.rd_frame_start) begin
      if (rd_valid_s) begin
        bank_s[rd_idx_s] = (latest_vld_s && (latest_s == rd_idx_s)) ? READY : FREE;
        rd_valid_s       = 1'b0;
      end else begin
        rd_valid_s = rd_valid_s;
      end
      if (latest_vld_s) begin
        bank_s[latest_s] = READING;
        rd_fresh_s       = ~seen_s[latest_s];
        seen_s[latest_s] = 1'b1;
        rd_idx_s         = latest_s;
        rd_valid_s       = 1'b1;
        rd_alloc_s       = 1'b1;
      end else begin
        rd_alloc_s = 1'b0;
      end
    end else begin
      rd_alloc_s = 1'b0;
    end
  end

  // State and registered outputs; init_done low holds everything in the reset state.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      bank_r           <= {NB{FREE}};
      seen_r           <= {NB{1'b0}};
      latest_r         <= {IDX_W{1'b0}};
      latest_vld_r     <= 1'b0;
      wr_idx_r         <= {IDX_W{1'b0}};
      rd_idx_r         <= {IDX_W{1'b0}};
      wr_grant_r       <= 1'b0;
      rd_valid_r       <= 1'b0;
      rd_fresh_r       <= 1'b0;
      wr_drop_r        <= 1'b0;
      wr_base_r        <= {ADDR_W{1'b0}};
      rd_base_r        <= {ADDR_W{1'b0}};
      frames_dropped_r <= 16'h0000;
    end else if (!init_done) begin
      bank_r           <= {NB{FREE}};
      seen_r           <= {NB{1'b0}};
      latest_r         <= {IDX_W{1'b0}};
      latest_vld_r     <= 1'b0;
      wr_idx_r         <= {IDX_W{1'b0}};
      rd_idx_r         <= {IDX_W{1'b0}};
      wr_grant_r       <= 1'b0;
      rd_valid_r       <= 1'b0;
      rd_fresh_r       <= 1'b0;
      wr_drop_r        <= 1'b0;
      wr_base_r        <= {ADDR_W{1'b0}};
      rd_base_r        <= {ADDR_W{1'b0}};
      frames_dropped_r <= 16'h0000;
    end else begin
      bank_r       <= bank_s;
      seen_r       <= seen_s;
      latest_r     <= latest_s;
      latest_vld_r <= latest_vld_s;
      wr_idx_r     <= wr_idx_s;
      rd_idx_r     <= rd_idx_s;
      wr_grant_r   <= wr_grant_s;
      rd_valid_r   <= rd_valid_s;
      rd_fresh_r   <= rd_fresh_s;
      wr_drop_r    <= wr_drop_s;
      if (wr_alloc_s) begin
        wr_base_r <= bank_base(wr_idx_s);
      end else begin
        wr_base_r <= wr_base_r;
      end
      if (rd_alloc_s) begin
        rd_base_r <= bank_base(rd_idx_s);
      end else begin
        rd_base_r <= rd_base_r;
      end
      if (drop_evt_s && (frames_dropped_r != 16'hFFFF)) begin
        frames_dropped_r <= frames_dropped_r + 16'd1;
      end else begin
        frames_dropped_r <= frames_dropped_r;
      end
    end
  end

  assign bus.wr_grant       = wr_grant_r;
  assign bus.wr_base        = wr_base_r;
  assign bus.wr_drop        = wr_drop_r;
  assign bus.rd_valid       = rd_valid_r;
  assign bus.rd_base        = rd_base_r;
  assign bus.rd_fresh       = rd_fresh_r;
  assign bus.frames_dropped = frames_dropped_r;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Self-checking bench for frame_bank_scheduler: directed scenarios, then random pulses
// compared against a bank-ownership model.
module tb_frame_bank_scheduler;

`ifdef FRAME_BANK_TRIPLE_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int BASE   = 32'h000000;
  localparam int STRIDE = 32'h040000;
  localparam int S_FREE = 0, S_WR = 1, S_RDY = 2, S_RD = 3;

  logic PixelClk = 1'b0;
  logic nRST     = 1'b0;
  logic init_done = 1'b0;

  frame_bank_scheduler_if #(.ADDR_W(21)) bus ();

  frame_bank_scheduler #(.ADDR_W(21)) dut (
    .PixelClk (PixelClk),
    .nRST     (nRST),
    .init_done(init_done),
    .bus      (bus)
  );

  always #5 PixelClk = ~PixelClk;

  int total = 0;
  int bad   = 0;

  int m_st [NB];
  bit m_seen [NB];
  int m_latest, m_w, m_r, m_wbase, m_rbase, m_cnt;
  bit m_fresh, m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_st[i] = S_FREE;
      m_seen[i] = 1'b0;
    end
    m_latest = -1; m_w = -1; m_r = -1;
    m_wbase = 0; m_rbase = 0; m_cnt = 0;
    m_fresh = 1'b0; m_drop = 1'b0;
  endtask

  task automatic model_apply(input bit ws, input bit wd, input bit wa, input bit rs, input bit rdn);
    int pick;
    bit evt;
    evt = 1'b0;
    m_drop = 1'b0;
    if (!init_done) begin
      model_reset();
      return;
    end
    if (rdn && m_r >= 0) begin
      m_st[m_r] = (m_latest == m_r) ? S_RDY : S_FREE;
      m_r = -1;
    end
    if (m_w >= 0 && wd) begin
      if (m_latest >= 0 && m_st[m_latest] == S_RDY) m_st[m_latest] = S_FREE;
      m_st[m_w] = S_RDY;
      m_seen[m_w] = 1'b0;
      m_latest = m_w;
      m_w = -1;
    end else if (m_w >= 0 && wa) begin
      m_st[m_w] = S_FREE;
      m_w = -1;
    end
    if (ws) begin
      if (m_w >= 0) begin
        m_st[m_w] = S_FREE;
        m_w = -1;
        evt = 1'b1;
      end
      pick = -1;
      for (int i = 0; i < NB; i++) if (pick < 0 && m_st[i] == S_FREE) pick = i;
      if (pick < 0) begin
        for (int i = 0; i < NB; i++) if (pick < 0 && m_st[i] == S_RDY) pick = i;
        if (pick >= 0) begin
          evt = 1'b1;
          if (m_latest == pick) m_latest = -1;
        end
      end
      if (pick >= 0) begin
        m_st[pick] = S_WR;
        m_w = pick;
        m_wbase = BASE + pick * STRIDE;
      end else begin
        m_drop = 1'b1;
        evt = 1'b1;
      end
    end
    if (rs) begin
      if (m_r >= 0) begin
        m_st[m_r] = (m_latest == m_r) ? S_RDY : S_FREE;
        m_r = -1;
      end
      if (m_latest >= 0) begin
        m_st[m_latest] = S_RD;
        m_fresh = !m_seen[m_latest];
        m_seen[m_latest] = 1'b1;
        m_r = m_latest;
        m_rbase = BASE + m_latest * STRIDE;
      end
    end
    if (evt && m_cnt < 65535) m_cnt++;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".wr_grant"}, 32'(bus.wr_grant), 32'(m_w >= 0));
    chk({ctx, ".wr_base"},  32'(bus.wr_base),  m_wbase);
    chk({ctx, ".wr_drop"},  32'(bus.wr_drop),  32'(m_drop));
    chk({ctx, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_r >= 0));
    chk({ctx, ".rd_base"},  32'(bus.rd_base),  m_rbase);
    if (m_r >= 0) chk({ctx, ".rd_fresh"}, 32'(bus.rd_fresh), 32'(m_fresh));
    chk({ctx, ".frames_dropped"}, 32'(bus.frames_dropped), m_cnt);
  endtask

  task automatic step(input string ctx, input bit ws, input bit wd, input bit wa,
                      input bit rs, input bit rdn);
    bus.wr_frame_start = ws;
    bus.wr_frame_done  = wd;
    bus.wr_frame_abort = wa;
    bus.rd_frame_start = rs;
    bus.rd_frame_done  = rdn;
    @(posedge PixelClk);
    model_apply(ws, wd, wa, rs, rdn);
    #1;
    bus.wr_frame_start = 1'b0;
    bus.wr_frame_done  = 1'b0;
    bus.wr_frame_abort = 1'b0;
    bus.rd_frame_start = 1'b0;
    bus.rd_frame_done  = 1'b0;
    check_outputs(ctx);
  endtask

  initial begin
    bus.wr_frame_start = 1'b0;
    bus.wr_frame_done  = 1'b0;
    bus.wr_frame_abort = 1'b0;
    bus.rd_frame_start = 1'b0;
    bus.rd_frame_done  = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    nRST = 1'b1;
    @(posedge PixelClk); #1;

    step("pre_init", 1, 0, 0, 0, 0);
    chk("pre_init_grant", 32'(bus.wr_grant), 32'd0);
    init_done = 1'b1;
    step("first_grant", 1, 0, 0, 0, 0);
    chk("first_grant_lvl", 32'(bus.wr_grant), 32'd1);
    chk("first_grant_base", 32'(bus.wr_base), 32'h000000);

    step("wr_done0", 0, 1, 0, 0, 0);
    step("rd_start0", 0, 0, 0, 1, 0);
    chk("rd0_fresh", 32'(bus.rd_fresh), 32'd1);
    step("rd_done0", 0, 0, 0, 0, 1);
    step("rd_again", 0, 0, 0, 1, 0);
    chk("rd_again_base", 32'(bus.rd_base), 32'h000000);
    chk("rd_again_fresh", 32'(bus.rd_fresh), 32'd0);

    step("wr_start1", 1, 0, 0, 0, 0);
    step("wr_done1", 0, 1, 0, 0, 0);
    step("wr_start_busy", 1, 0, 0, 0, 0);
`ifdef FRAME_BANK_TRIPLE_EN
    chk("triple_base", 32'(bus.wr_base), 32'h080000);
    chk("triple_cnt", 32'(bus.frames_dropped), 32'd0);
`else
    chk("double_reclaim_base", 32'(bus.wr_base), 32'h040000);
    chk("double_reclaim_cnt", 32'(bus.frames_dropped), 32'd1);
`endif
    step("abort", 0, 0, 1, 0, 0);
    chk("abort_grant", 32'(bus.wr_grant), 32'd0);
    step("regrant", 1, 0, 0, 0, 0);
`ifdef FRAME_BANK_TRIPLE_EN
    chk("regrant_base", 32'(bus.wr_base), 32'h080000);
    chk("regrant_cnt", 32'(bus.frames_dropped), 32'd0);
`else
    chk("regrant_base", 32'(bus.wr_base), 32'h040000);
    chk("regrant_cnt", 32'(bus.frames_dropped), 32'd1);
`endif
    step("done_and_read", 0, 1, 0, 1, 0);
`ifdef FRAME_BANK_TRIPLE_EN
    chk("handoff_base", 32'(bus.rd_base), 32'h080000);
`else
    chk("handoff_base", 32'(bus.rd_base), 32'h040000);
`endif
    chk("handoff_fresh", 32'(bus.rd_fresh), 32'd1);

    step("pre_rst", 1, 0, 0, 0, 0);
    nRST = 1'b0;
    #2;
    model_reset();
    check_outputs("async_rst");
    #2;
    nRST = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      init_done = ($urandom_range(0, 299) != 0);
      step("rand",
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_bank_scheduler.md
# frame_bank_scheduler

Arbitrates PSRAM frame-buffer banks between the camera write path and the LCD read path, so neither ever touches a frame the other is still using. It sits in the PixelClk domain beside the frame buffer and video controller. It takes frame start/done pulses from both sides and returns the base address of the granted bank to each side. It replaces the bare `buffer_flip` bit with tracked bank ownership, drop accounting and newest-frame selection.

## Interface
- `ADDR_W`, 21, width of bank base addresses (PSRAM word address).
- `BASE_ADDR`, 21'h000000, address of bank 0.
- `BANK_STRIDE`, 21'h040000, word distance between consecutive banks.
- `PixelClk`  in  1  clock; all logic on rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `init_done`  in  1  PSRAM calibrated; level, synchronous to PixelClk.
- `wr_frame_start`  in  1  one-cycle pulse: writer requests a bank for a new frame.
- `wr_frame_done`  in  1  one-cycle pulse: writer completed the frame.
- `wr_frame_abort`  in  1  one-cycle pulse: writer frame incomplete; discard it.
- `wr_grant`  out  1  level: writer owns bank at `wr_base`.
- `wr_base`  out  ADDR_W  base address of writer bank.
- `wr_drop`  out  1  one-cycle pulse: start refused; writer discards the frame.
- `rd_frame_start`  in  1  one-cycle pulse: reader requests the newest frame.
- `rd_frame_done`  in  1  one-cycle pulse: reader finished scanning out.
- `rd_valid`  out  1  level: reader owns bank at `rd_base`.
- `rd_base`  out  ADDR_W  base address of reader bank.
- `rd_fresh`  out  1  level, qualified by `rd_valid`: granted frame not previously read.
- `frames_dropped`  out  16  count of lost frames; saturates at 16'hFFFF.

## Operation
- Each bank has a state: FREE, WRITING, READY or READING. Each bank also has a `seen` flag. A `latest` index points at the newest completed frame.
- Bank count NB: 3 with `FRAME_BANK_TRIPLE_EN`, 2 without it.
- **Writer start:**
  - Grant the lowest-index FREE bank.
  - If no bank is FREE, reclaim the lowest-index READY bank not being read. Its frame is lost: increment `frames_dropped`. If that bank was `latest`, clear the `latest` valid bit.
  - If neither is available, pulse `wr_drop`, increment `frames_dropped` and leave `wr_grant` low.
- **Writer start while `wr_grant` is high:** free the current bank, increment `frames_dropped`, then allocate as above.
- **Writer done:**
  - The WRITING bank becomes READY, with `seen` cleared, and becomes `latest`.
  - The previous `latest` bank becomes FREE if it is READY. If it is READING, it becomes FREE when the reader releases it.
  - `wr_grant` drops.
- **Writer abort:** the WRITING bank becomes FREE; `wr_grant` drops. No count.
- **Reader start:** if `latest` is valid, that bank becomes READING. `rd_fresh` is set to the inverse of `seen`, then `seen` is set and `rd_valid` rises. If `latest` is not valid, `rd_valid` stays 0 and `rd_base` holds its value.
- **Reader start while `rd_valid` is high:** release the current bank, then acquire.
- **Reader done:** the bank returns to READY if it is still `latest`, otherwise to FREE. `rd_valid` drops.
- **Ignored inputs:** `wr_frame_done` or `wr_frame_abort` without `wr_grant`, and `rd_frame_done` without `rd_valid`.
- **Before `init_done`:** all requests are ignored and no counts change.
- **`init_done` falling:** synchronous clear to the reset state.

## Timing
- Reset values: all banks FREE, `latest` invalid. All outputs are 0, including `wr_base`, `rd_base` and `frames_dropped`.
- All outputs are registered. `wr_grant`/`wr_base`, `rd_valid`/`rd_base`/`rd_fresh` and `wr_drop` update on the edge after the request pulse (1-cycle latency). `wr_drop` lasts exactly 1 cycle.
- Release by done/abort is visible to an allocation in the same cycle. Processing order within a cycle:
  1. `rd_frame_done`
  2. `wr_frame_done` / `wr_frame_abort`
  3. `wr_frame_start`
  4. `rd_frame_start`
- Consequence: `wr_frame_done` together with `rd_frame_start` hands the reader the just-completed frame.
- Base address = `BASE_ADDR + index*BANK_STRIDE`, truncated to ADDR_W.
- Counter increments at most 1 per cycle; when two drop events coincide, it still increments by 1.

## Configuration
- `FRAME_BANK_TRIPLE_EN` defined: NB=3.
  - The writer always finds a FREE bank, because at most one bank is READING and one is READY besides its own.
  - `wr_drop` never fires in legal operation.
- Undefined: NB=2 (double buffering).
  - Unread frames may be reclaimed (counted as dropped).
  - `wr_drop` fires when the reader holds one bank and the writer requests while the other bank is unavailable.

## Test plan
- Before `init_done`: pulse `wr_frame_start` -> `wr_grant` stays 0 and `frames_dropped` stays 0. After `init_done`=1, pulse `wr_frame_start` -> next cycle `wr_grant`=1, `wr_base`=21'h000000.
- Write frame to bank 0 (done), then `rd_frame_start` -> `rd_valid`=1, `rd_base`=0, `rd_fresh`=1. Done, then `rd_frame_start` again -> `rd_base`=0, `rd_fresh`=0.
- Triple mode: reader holds bank 0, bank 1 READY. `wr_frame_start` -> `wr_base`=21'h080000, `frames_dropped`=0.
- Double mode: reader holds bank 0, bank 1 READY unread. `wr_frame_start` -> `wr_base`=21'h040000, `frames_dropped`=1.
- Double mode: reader on bank 0, writer on bank 1. `wr_frame_abort`, then `wr_frame_start` -> re-grants bank 1, no drop.
- `wr_frame_done` and `rd_frame_start` in the same cycle -> reader gets the just-completed bank.
- Assert `nRST` mid-frame -> all outputs 0 immediately, with `frames_dropped` cleared.
